// File: rtl/cpu_seq_multi.sv
// ============================================================================
// cpu_seq_multi
// ----------------------------------------------------------------------------
// Instruction sequencer for a multi-cycle CPU. Each instruction spends one
// FETCH cycle and then one or more EXEC stages (up to NEXEC). When PIPELINED
// is non-zero, the next fetch is overlapped with the completing EXEC stage,
// so completion returns straight to EXEC[0]. Adds stall, branch flush,
// halt/resume and a retired-instruction counter.
//
// Parameters:
//   NEXEC      maximum execute stages per instruction (>= 1)
//   PIPELINED  1: completion -> EXEC[0]; 0: completion -> FETCH
//   CNTW       width of the retired-instruction counter
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   STALL      freeze state, counter and error flag this cycle
//   EXT        current instruction needs the next EXEC stage
//   FLUSH      discard the overlapped fetch (completing cycle only)
//   HALT_REQ   halt after the current instruction (completing cycle only)
//   RESUME     leave the halted state
//   FETCH      fetch-stage enable
//   EXEC       one-hot execute-stage enable, bit k = stage k+1
//   HALTED     sequencer is halted
//   RETIRE     combinational: instruction completes at the next edge
//   INSTR_CNT  retired-instruction count (wraps)
//   EXT_ERR    sticky: EXT was asserted in the last EXEC stage
// ============================================================================
module cpu_seq_multi #(
    parameter int NEXEC     = 2,
    parameter int PIPELINED = 1,
    parameter int CNTW      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STALL,
    input  logic             EXT,
    input  logic             FLUSH,
    input  logic             HALT_REQ,
    input  logic             RESUME,
    output logic             FETCH,
    output logic [NEXEC-1:0] EXEC,
    output logic             HALTED,
    output logic             RETIRE,
    output logic [CNTW-1:0]  INSTR_CNT,
    output logic             EXT_ERR
);

    localparam logic [NEXEC-1:0] EXEC_FIRST = NEXEC'(1);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e            state_q;
    logic              fetch_q;
    logic              halted_q;
    logic              ext_err_q;
    logic [NEXEC-1:0]  exec_q;
    logic [CNTW-1:0]   cnt_q;

    logic [NEXEC-1:0]  exec_shift_d;
    logic [CNTW-1:0]   cnt_d;
    logic              last_stage;
    logic              complete;

    // The one-hot EXEC register doubles as the stage index: the top bit
    // marks the last stage, and a left shift advances to the next stage.
    assign last_stage   = exec_q[NEXEC-1];
    assign complete     = (state_q == ST_EXEC) && (!EXT || last_stage);
    assign exec_shift_d = exec_q << 1;
    assign cnt_d        = cnt_q + CNTW'(1);

    // Retire is the only output not taken straight from a register; it must
    // be masked by STALL because a stalled completion does not take effect.
    assign RETIRE = complete && !STALL;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_FETCH;
            fetch_q   <= 1'b1;
            exec_q    <= '0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
            ext_err_q <= 1'b0;
        end else if (!STALL) begin
            case (state_q)
                ST_FETCH: begin
                    state_q <= ST_EXEC;
                    fetch_q <= 1'b0;
                    exec_q  <= EXEC_FIRST;
                end

                ST_EXEC: begin
                    if (complete) begin
                        cnt_q <= cnt_d;
                        // Completion with EXT high can only happen in the
                        // last stage, so EXT here means an overrun.
                        if (EXT) begin
                            ext_err_q <= 1'b1;
                        end
                        if (HALT_REQ) begin
                            state_q  <= ST_HALT;
                            exec_q   <= '0;
                            halted_q <= 1'b1;
                        end else if (FLUSH || (PIPELINED == 0)) begin
                            state_q <= ST_FETCH;
                            exec_q  <= '0;
                            fetch_q <= 1'b1;
                        end else begin
                            exec_q <= EXEC_FIRST;
                        end
                    end else begin
                        exec_q <= exec_shift_d;
                    end
                end

                ST_HALT: begin
                    // Always refetch on resume: any overlapped fetch from
                    // before the halt is stale.
                    if (RESUME) begin
                        state_q  <= ST_FETCH;
                        halted_q <= 1'b0;
                        fetch_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q  <= ST_FETCH;
                    fetch_q  <= 1'b1;
                    exec_q   <= '0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign FETCH     = fetch_q;
    assign EXEC      = exec_q;
    assign HALTED    = halted_q;
    assign INSTR_CNT = cnt_q;
    assign EXT_ERR   = ext_err_q;

endmodule

// File: tb/tb_cpu_seq_multi.sv
// ============================================================================
// tb_cpu_seq_multi
// ----------------------------------------------------------------------------
// Three sequencer instances with different parameter sets share one input
// stream; each is compared every cycle against a behavioural model that
// tracks "which stage is the instruction in" as a plain integer.
//   A: NEXEC=2, PIPELINED=1, CNTW=16  (legacy-compatible default)
//   B: NEXEC=4, PIPELINED=1, CNTW=4   (deep extension, counter wrap)
//   C: NEXEC=1, PIPELINED=0, CNTW=8   (single stage, non-overlapped)
// ============================================================================
module tb_cpu_seq_multi;

    localparam int NA = 2, PA = 1, WA = 16;
    localparam int NB = 4, PB = 1, WB = 4;
    localparam int NC = 1, PC = 0, WC = 8;

    logic CLK = 1'b0;
    logic RST;
    logic STALL, EXT, FLUSH, HALT_REQ, RESUME;

    logic          a_fetch, a_halted, a_retire, a_err;
    logic [NA-1:0] a_exec;
    logic [WA-1:0] a_cnt;
    logic          b_fetch, b_halted, b_retire, b_err;
    logic [NB-1:0] b_exec;
    logic [WB-1:0] b_cnt;
    logic          c_fetch, c_halted, c_retire, c_err;
    logic [NC-1:0] c_exec;
    logic [WC-1:0] c_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // st: 0 = fetch, k >= 1 = execute stage k, -1 = halted
    typedef struct {
        int st;
        int cnt;
        bit err;
    } mdl_t;

    mdl_t ma, mb, mc;

    always #5 CLK = ~CLK;

    cpu_seq_multi #(.NEXEC(NA), .PIPELINED(PA), .CNTW(WA)) u_a (
        .CLK(CLK), .RST(RST), .STALL(STALL), .EXT(EXT), .FLUSH(FLUSH),
        .HALT_REQ(HALT_REQ), .RESUME(RESUME), .FETCH(a_fetch), .EXEC(a_exec),
        .HALTED(a_halted), .RETIRE(a_retire), .INSTR_CNT(a_cnt), .EXT_ERR(a_err)
    );
    cpu_seq_multi #(.NEXEC(NB), .PIPELINED(PB), .CNTW(WB)) u_b (
        .CLK(CLK), .RST(RST), .STALL(STALL), .EXT(EXT), .FLUSH(FLUSH),
        .HALT_REQ(HALT_REQ), .RESUME(RESUME), .FETCH(b_fetch), .EXEC(b_exec),
        .HALTED(b_halted), .RETIRE(b_retire), .INSTR_CNT(b_cnt), .EXT_ERR(b_err)
    );
    cpu_seq_multi #(.NEXEC(NC), .PIPELINED(PC), .CNTW(WC)) u_c (
        .CLK(CLK), .RST(RST), .STALL(STALL), .EXT(EXT), .FLUSH(FLUSH),
        .HALT_REQ(HALT_REQ), .RESUME(RESUME), .FETCH(c_fetch), .EXEC(c_exec),
        .HALTED(c_halted), .RETIRE(c_retire), .INSTR_CNT(c_cnt), .EXT_ERR(c_err)
    );

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st  = 0;
        r.cnt = 0;
        r.err = 1'b0;
        return r;
    endfunction

    // One clock edge of the sequencer, written from the instruction's view.
    function automatic mdl_t mdl_step(mdl_t m, int n, int pipe, int w,
                                      bit stall, bit ext, bit flush,
                                      bit hreq, bit resume);
        mdl_t r = m;
        if (stall) return r;
        if (m.st == 0) begin
            r.st = 1;
        end else if (m.st == -1) begin
            if (resume) r.st = 0;
        end else if (ext && m.st < n) begin
            r.st = m.st + 1;
        end else begin
            r.cnt = (m.cnt + 1) % (1 << w);
            if (ext) r.err = 1'b1;
            if (hreq)           r.st = -1;
            else if (flush)     r.st = 0;
            else if (pipe != 0) r.st = 1;
            else                r.st = 0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string name, input mdl_t m, input int n,
                           input logic fetch, input logic [31:0] exec,
                           input logic halted, input logic retire,
                           input logic [31:0] cnt, input logic err);
        logic [31:0] exp_exec;
        logic        exp_ret;
        exp_exec = (m.st >= 1) ? (32'd1 << (m.st - 1)) : 32'd0;
        exp_ret  = !STALL && (m.st >= 1) && (!EXT || m.st == n);
        chk({name, ".FETCH"},     32'(fetch),  32'(m.st == 0));
        chk({name, ".EXEC"},      exec,        exp_exec);
        chk({name, ".HALTED"},    32'(halted), 32'(m.st == -1));
        chk({name, ".RETIRE"},    32'(retire), 32'(exp_ret));
        chk({name, ".INSTR_CNT"}, cnt,         32'(m.cnt));
        chk({name, ".EXT_ERR"},   32'(err),    32'(m.err));
    endtask

    task automatic check_all();
        chk_dut("A", ma, NA, a_fetch, 32'(a_exec), a_halted, a_retire, 32'(a_cnt), a_err);
        chk_dut("B", mb, NB, b_fetch, 32'(b_exec), b_halted, b_retire, 32'(b_cnt), b_err);
        chk_dut("C", mc, NC, c_fetch, 32'(c_exec), c_halted, c_retire, 32'(c_cnt), c_err);
    endtask

    // Called between edges: apply inputs, check, then advance one edge.
    task automatic cycle(input bit s, input bit e, input bit f,
                         input bit h, input bit r);
        STALL = s; EXT = e; FLUSH = f; HALT_REQ = h; RESUME = r;
        #1;
        check_all();
        @(posedge CLK);
        ma = mdl_step(ma, NA, PA, WA, s, e, f, h, r);
        mb = mdl_step(mb, NB, PB, WB, s, e, f, h, r);
        mc = mdl_step(mc, NC, PC, WC, s, e, f, h, r);
        #2;
    endtask

    initial begin
        RST = 1'b1;
        STALL = 1'b0; EXT = 1'b0; FLUSH = 1'b0; HALT_REQ = 1'b0; RESUME = 1'b0;
        ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
        #12;
        check_all();
        RST = 1'b0;

        // Basic: five simple instructions.
        repeat (6) cycle(0, 0, 0, 0, 0);

        // Extension run through all stages, overrunning the deepest one.
        repeat (6) cycle(0, 1, 0, 0, 0);

        // Stall held for three cycles, then a flushing completion.
        cycle(0, 1, 0, 0, 0);
        repeat (3) cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);

        // Halt wins over flush; hold, stalled resume, real resume.
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        repeat (4) cycle(0, 1, 1, 1, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset pulse between clock edges.
        repeat (2) cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
        RST = 1'b1;
        STALL = 1'b0; EXT = 1'b0; FLUSH = 1'b0; HALT_REQ = 1'b0; RESUME = 1'b0;
        #1;
        ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
        check_all();
        RST = 1'b0;
        #1;

        // Long run of simple instructions to wrap the narrow counter.
        repeat (40) cycle(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
